// File: rtl/conbus_pkg.sv
// ---------------------------------------------------------------------------
// conbus_pkg
//
// Shared definitions for the conbus round-robin arbiter and its helpers.
//   - conbus_state_e : arbiter FSM state encoding (IDLE / OWN / ERR)
//   - DEF_N_MASTERS  : default number of bus masters on the interconnect
//   - DEF_TIMEOUT    : default watchdog stall limit in cycles (0 = disabled)
//   - DEF_ERRCNT_W   : default width of the watchdog event counter
//   - MAX_MASTERS    : widest request vector onehot_to_idx can decode
//   - onehot_to_idx  : one-hot vector to binary index
// ---------------------------------------------------------------------------
package conbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // parked: grant held, owner has no request
        ST_OWN  = 2'd1,   // a master owns the bus and is being watched
        ST_ERR  = 2'd2    // one-cycle watchdog termination
    } conbus_state_e;

    localparam int DEF_N_MASTERS = 7;
    localparam int DEF_TIMEOUT   = 1023;
    localparam int DEF_ERRCNT_W  = 8;
    localparam int MAX_MASTERS   = 32;

    // Index of the set bit in a one-hot vector. The OR-of-indices form keeps
    // this a flat OR tree in hardware; a zero vector decodes to index 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// ---------------------------------------------------------------------------
// conbus_rr_pick
//
// Combinational rotating-priority encoder. Starting just after the last
// owner, masters are searched in the order owner+1, owner+2, ... owner+N-1,
// then owner itself (all mod N); the first requester wins. The last owner
// therefore always has the lowest priority.
//
// Ports:
//   req   in  N_MASTERS  request vector (one bit per master)
//   owner in  IDX_W      index of the most recent owner
//   pick  out N_MASTERS  one-hot winner, all zero when nobody requests
//   valid out 1          at least one request is present
// ---------------------------------------------------------------------------
module conbus_rr_pick #(
    parameter int N_MASTERS = 7,
    parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     owner,
    output logic [N_MASTERS-1:0] pick,
    output logic                 valid
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // Offset N wraps back to the owner itself, so it is checked last.
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = IDX_W'((int'(owner) + i) % N_MASTERS);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/conbus_rr_arb_wdt.sv
// ---------------------------------------------------------------------------
// conbus_rr_arb_wdt
//
// Round-robin arbiter for the shared Wishbone bus of the conbus interconnect,
// with a stall watchdog. The registered one-hot gnt vector steers the master
// mux; a master keeps the bus for as long as it holds cyc (req). If the
// granted master's strobe goes unanswered for TIMEOUT cycles the transfer is
// terminated with a one-cycle bus_err pulse and err_count is bumped.
//
// Bus handshake seen by this block: a beat is offered while the owner holds
// req (cyc) and stb; it completes in the cycle ack is high. A cycle with
// req[owner] & stb & !ack is a stalled cycle; anything else resets the
// stall count. ack always wins over an expiring watchdog.
//
// Ports:
//   sys_clk   in  1         system clock, rising edge
//   sys_rst   in  1         synchronous active-high reset
//   req       in  N_MASTERS per-master cyc
//   stb       in  1         stb of the currently granted master
//   ack       in  1         OR of all slave acks
//   gnt       out N_MASTERS one-hot grant, registered
//   bus_err   out 1         one-cycle termination pulse (qualified by gnt
//                           in the interconnect)
//   err_count out ERRCNT_W  saturating count of watchdog terminations
//   dbg_state out 2         current FSM state (conbus_state_e encoding)
// ---------------------------------------------------------------------------
module conbus_rr_arb_wdt
    import conbus_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,   // up to MAX_MASTERS
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int ERRCNT_W  = DEF_ERRCNT_W
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 stb,
    input  logic                 ack,
    output logic [N_MASTERS-1:0] gnt,
    output logic                 bus_err,
    output logic [ERRCNT_W-1:0]  err_count,
    output logic [1:0]           dbg_state
);

    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    // wdt only ever reaches TIMEOUT-1; one bit is kept when disabled.
    localparam int WDT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDT_EN = (TIMEOUT != 0);

    localparam logic [WDT_W-1:0]    WDT_LAST = WDT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ERRCNT_W-1:0] ERR_MAX  = '1;
    localparam logic [IDX_W-1:0]    OWNER_RST = IDX_W'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] GNT_RST  = N_MASTERS'(1);

    conbus_state_e          state;
    logic [IDX_W-1:0]       owner;
    logic [WDT_W-1:0]       wdt;

    logic [N_MASTERS-1:0]   pick;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   req_owner;
    logic                   stalled;

    conbus_rr_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req   (req),
        .owner (owner),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign pick_idx  = IDX_W'(onehot_to_idx(MAX_MASTERS'(pick)));
    assign req_owner = req[owner];
    assign stalled   = WDT_EN && stb && req_owner && !ack;
    assign dbg_state = state;

    // Single-process FSM: gnt, owner, wdt, bus_err and err_count are all
    // registered here so every output changes exactly one edge after the
    // inputs that decided it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            gnt       <= GNT_RST;
            owner     <= OWNER_RST;
            wdt       <= '0;
            bus_err   <= 1'b0;
            err_count <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdt <= '0;
                    // Any request leaves park; the pointer still points at the
                    // last real owner, so it is served last.
                    if (pick_valid) begin
                        gnt   <= pick;
                        owner <= pick_idx;
                        state <= ST_OWN;
                    end
                end

                ST_OWN: begin
                    if (req_owner) begin
                        // Owner keeps the bus; only the watchdog can end it.
                        if (stalled) begin
                            if (wdt == WDT_LAST) begin
                                state   <= ST_ERR;
                                wdt     <= '0;
                                bus_err <= 1'b1;
                                if (err_count != ERR_MAX) begin
                                    err_count <= err_count + 1'b1;
                                end
                            end else begin
                                wdt <= wdt + 1'b1;
                            end
                        end else begin
                            wdt <= '0;
                        end
                    end else if (pick_valid) begin
                        // Owner released; hand over directly without parking.
                        gnt   <= pick;
                        owner <= pick_idx;
                        wdt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                        wdt   <= '0;
                    end
                end

                ST_ERR: begin
                    // bus_err is high during this state only; the watchdog is
                    // not counting here.
                    wdt <= '0;
                    if (req_owner) begin
                        state <= ST_OWN;
                    end else if (pick_valid) begin
                        gnt   <= pick;
                        owner <= pick_idx;
                        state <= ST_OWN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    wdt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conbus_rr_arb_wdt.sv
// ---------------------------------------------------------------------------
// tb_conbus_rr_arb_wdt
//
// Scoreboard bench for conbus_rr_arb_wdt (N=7, TIMEOUT=4, ERRCNT_W=2).
// The driver applies one input vector per cycle and feeds it to a reference
// model built from the arbitration rules (rotating search, stall run length,
// saturating count); the predicted outputs for the next cycle are queued.
// A monitor process pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_conbus_rr_arb_wdt;
    import conbus_pkg::*;

    localparam int N       = 7;
    localparam int TO      = 4;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int EXP_W   = N + 1 + CW + 2;

    // Reference-model modes.
    localparam int M_IDLE = 0;
    localparam int M_OWN  = 1;
    localparam int M_ERR  = 2;

    // ---------------- clock / reset ----------------
    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [N-1:0]  req     = '0;
    logic          stb     = 1'b0;
    logic          ack     = 1'b0;
    logic [N-1:0]  gnt;
    logic          bus_err;
    logic [CW-1:0] err_count;
    logic [1:0]    dbg_state;

    always #5 sys_clk = ~sys_clk;

    conbus_rr_arb_wdt #(
        .N_MASTERS (N),
        .TIMEOUT   (TO),
        .ERRCNT_W  (CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .stb       (stb),
        .ack       (ack),
        .gnt       (gnt),
        .bus_err   (bus_err),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    int cyc_n = 0;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode  = M_IDLE;
    int m_owner = N - 1;
    int m_gnt   = 0;
    int m_run   = 0;
    int m_cnt   = 0;

    function automatic int rr_winner(input logic [N-1:0] r, input int last);
        for (int d = 1; d <= N; d++) begin
            if (r[(last + d) % N]) return (last + d) % N;
        end
        return last;
    endfunction

    task automatic model_grant(input logic [N-1:0] r);
        m_owner = rr_winner(r, m_owner);
        m_gnt   = m_owner;
        m_mode  = M_OWN;
        m_run   = 0;
    endtask

    task automatic model_step(input logic rst, input logic [N-1:0] r, input logic s, input logic a);
        if (rst) begin
            m_mode = M_IDLE; m_owner = N - 1; m_gnt = 0; m_run = 0; m_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            if (r != '0) model_grant(r);
        end else if (m_mode == M_OWN) begin
            if (r[m_owner]) begin
                if (s && !a) begin
                    m_run++;
                    if (TO != 0 && m_run == TO) begin
                        m_mode = M_ERR;
                        m_run  = 0;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (r != '0) begin
                model_grant(r);
            end else begin
                m_mode = M_IDLE;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
            if (r[m_owner])    m_mode = M_OWN;
            else if (r != '0)  model_grant(r);
            else               m_mode = M_IDLE;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               cyc_q[$];

    task automatic push_expected(input int target);
        logic [N-1:0]  g;
        logic [1:0]    st;
        logic [CW-1:0] c;
        g = '0;
        g[m_gnt] = 1'b1;
        c = CW'(m_cnt);
        case (m_mode)
            M_OWN:   st = ST_OWN;
            M_ERR:   st = ST_ERR;
            default: st = ST_IDLE;
        endcase
        exp_q.push_back({g, (m_mode == M_ERR), c, st});
        cyc_q.push_back(target);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [N-1:0] r, input logic s, input logic a);
        @(posedge sys_clk);
        #1;
        sys_rst = rst; req = r; stb = s; ack = a;
        model_step(rst, r, s, a);
        push_expected(cyc_n + 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        logic [EXP_W-1:0] e;
        int               c;
        while (cyc_q.size() != 0 && cyc_q[0] <= cyc_n) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("sb_sched", 32'(cyc_n), 32'(c));
            check("gnt", 32'(gnt), 32'(e[EXP_W-1 -: N]));
            check("bus_err", 32'(bus_err), 32'(e[CW+2]));
            check("err_count", 32'(err_count), 32'(e[CW+1 -: CW]));
            check("state", 32'(dbg_state), 32'(e[1:0]));
        end
    end

    // Grant-order recorder for the all-masters rotation scenario.
    logic         rr_rec   = 1'b0;
    logic [N-1:0] rr_prev  = '0;
    logic         rr_owned = 1'b0;
    int           got_q[$];

    always @(negedge sys_clk) begin
        if (rr_rec && got_q.size() < 8) begin
            if (dbg_state == ST_OWN && (!rr_owned || gnt != rr_prev)) begin
                for (int i = 0; i < N; i++) begin
                    if (gnt[i]) got_q.push_back(i);
                end
            end
            rr_prev  = gnt;
            rr_owned = (dbg_state == ST_OWN);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] r;
        logic         s, a, rst;
        int           age, old_owner, old_mode, len, mode;

        // Reset, then idle with no requests.
        repeat (3) drive(1'b1, '0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, '0, 1'b0, 1'b0);

        // Masters 1 and 2 request; master 1 drops, then returns.
        repeat (4) drive(1'b0, 7'b0000110, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 7'b0000100, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 7'b0000110, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 7'b0000000, 1'b0, 1'b0);

        // Everyone requests; each owner releases for one cycle after 2 cycles.
        drive(1'b1, '0, 1'b0, 1'b0);
        rr_rec = 1'b1;
        age = 0;
        for (int t = 0; t < 60 && got_q.size() < 8; t++) begin
            r = '1;
            if (m_mode == M_OWN && age >= 2) r[m_owner] = 1'b0;
            old_owner = m_owner;
            old_mode  = m_mode;
            drive(1'b0, r, 1'b0, 1'b0);
            if (m_mode == M_OWN && old_mode == M_OWN && m_owner == old_owner) age++;
            else age = 1;
        end
        rr_rec = 1'b0;
        check("rr_len", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < got_q.size(); i++) begin
            check("rr_order", 32'(got_q[i]), 32'(i % N));
        end

        // Stall with no ack: one termination, then the stall continues.
        repeat (2) drive(1'b0, 7'b0001000, 1'b0, 1'b0);
        repeat (8) drive(1'b0, 7'b0001000, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 7'b0001000, 1'b0, 1'b0);
        // ack on the 4th stalled cycle, then a 3-cycle stall.
        repeat (3) drive(1'b0, 7'b0001000, 1'b1, 1'b0);
        drive(1'b0, 7'b0001000, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 7'b0001000, 1'b1, 1'b0);
        drive(1'b0, 7'b0001000, 1'b0, 1'b0);
        // Owner drops req on the would-be expiry cycle.
        repeat (3) drive(1'b0, 7'b0001000, 1'b1, 1'b0);
        drive(1'b0, 7'b0000000, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 7'b0000000, 1'b0, 1'b0);

        // Repeated timeouts saturate the 2-bit counter, then reset mid-stall.
        repeat (27) drive(1'b0, 7'b0000100, 1'b1, 1'b0);
        drive(1'b1, 7'b0000100, 1'b1, 1'b0);
        repeat (6) drive(1'b0, 7'b0000000, 1'b1, 1'b0);

        // Randomized phases: held request patterns, mixed ack behaviour.
        for (int p = 0; p < 150; p++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) begin
                r = '0;
                r[$urandom_range(0, N - 1)] = 1'b1;
            end
            len  = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            for (int c = 0; c < len; c++) begin
                s   = ($urandom_range(0, 3) != 0);
                a   = (mode == 0) ? 1'($urandom_range(0, 1)) :
                      (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
                rst = ($urandom_range(0, 199) == 0);
                drive(rst, r, s, a);
            end
        end

        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
